axis_channel_loader: RTL and testbench

Sequences the 16-way PS-to-PL AXI-Stream channel fan-out. A command carries a channel mask and a per-channel beat count. The block walks the set mask bits from lowest index to highest and drives a one-hot channel_select for each channel in turn. For each channel it gates the stream handshake so that exactly cmd_beats beats reach that channel before it moves to the next. It sits between the PS stream source and the channel router; the router's tdata path is untouched.

---
 rtl/axis_channel_loader.sv | 164 ++++++++++++++++
 tb/tb_axis_channel_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_channel_loader.sv
// Walks the set bits of a channel mask lowest-first, selecting one router channel at a
// time and gating the PS stream so exactly cmd_beats beats reach each selected channel.
module axis_channel_loader #(
    parameter int NUM_CH = 16,
    parameter int BEAT_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [NUM_CH-1:0] cmd_mask,
    input  logic [BEAT_W-1:0] cmd_beats,
    input  logic              abort,
    output logic [NUM_CH-1:0] channel_select,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [IDX_W-1:0]  cur_index,
    output logic [BEAT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] remaining_q, remaining_d;
    logic [BEAT_W-1:0] target_q, target_d;
    logic [NUM_CH-1:0] channel_select_q, channel_select_d;
    logic [IDX_W-1:0]  cur_index_q, cur_index_d;
    logic [BEAT_W-1:0] beat_count_q, beat_count_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              beat_fire;
    logic              last_beat;
    logic              degenerate;
    logic [NUM_CH-1:0] rem_clr;
    logic [NUM_CH-1:0] pe_in;
    logic [IDX_W-1:0]  pe_idx;
    logic              pe_any;

    assign beat_fire  = (state_q == S_STREAM) && s_axis_tvalid && m_axis_tready;
    assign last_beat  = beat_fire && (beat_count_q == (target_q - BEAT_W'(1)));
    assign degenerate = (cmd_mask == '0) || (cmd_beats == '0);
    assign rem_clr    = remaining_q & ~channel_select_q;

    // One priority encoder serves both the first pick in IDLE and the next pick in STREAM.
    assign pe_in = (state_q == S_IDLE) ? cmd_mask : rem_clr;

    always_comb begin
        pe_idx = '0;
        pe_any = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pe_in[i]) begin
                pe_idx = IDX_W'(i);
                pe_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            remaining_q      <= '0;
            target_q         <= '0;
            channel_select_q <= '0;
            cur_index_q      <= '0;
            beat_count_q     <= '0;
            done_q           <= 1'b0;
            aborted_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            remaining_q      <= remaining_d;
            target_q         <= target_d;
            channel_select_q <= channel_select_d;
            cur_index_q      <= cur_index_d;
            beat_count_q     <= beat_count_d;
            done_q           <= done_d;
            aborted_q        <= aborted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) state_d = degenerate ? S_DONE : S_SELECT;
            end
            S_SELECT: state_d = abort ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (abort)          state_d = S_DONE;
                else if (last_beat) state_d = pe_any ? S_SELECT : S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        remaining_d      = remaining_q;
        target_d         = target_q;
        channel_select_d = channel_select_q;
        cur_index_d      = cur_index_q;
        beat_count_d     = beat_count_q;
        aborted_d        = aborted_q;
        done_d           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    remaining_d  = cmd_mask;
                    target_d     = cmd_beats;
                    aborted_d    = 1'b0;
                    beat_count_d = '0;
                    if (!degenerate) begin
                        channel_select_d = NUM_CH'(1) << pe_idx;
                        cur_index_d      = pe_idx;
                    end
                end
            end
            S_SELECT: begin
                if (abort) aborted_d = 1'b1;
            end
            S_STREAM: begin
                if (beat_fire) beat_count_d = beat_count_q + BEAT_W'(1);
                // Abort beats the last beat: the channel is not advanced.
                if (abort) begin
                    aborted_d = 1'b1;
                end else if (last_beat) begin
                    remaining_d  = rem_clr;
                    beat_count_d = '0;
                    if (pe_any) begin
                        channel_select_d = NUM_CH'(1) << pe_idx;
                        cur_index_d      = pe_idx;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == S_DONE) begin
            channel_select_d = '0;
            done_d           = 1'b1;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign m_axis_tvalid  = s_axis_tvalid & (state_q == S_STREAM);
    assign s_axis_tready  = m_axis_tready & (state_q == S_STREAM);
    assign channel_select = channel_select_q;
    assign cur_index      = cur_index_q;
    assign beat_count     = beat_count_q;
    assign done           = done_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_axis_channel_loader.sv
// Directed bench for axis_channel_loader: inputs change 1 ns after each rising edge,
// outputs are sampled 2 ns after it.
module tb_axis_channel_loader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_mask;
    logic [15:0] cmd_beats;
    logic        abort;
    logic [15:0] channel_select;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  cur_index;
    logic [15:0] beat_count;

    int total;
    int bad;

    // {cmd_ready, busy, done, aborted, m_axis_tvalid, s_axis_tready}
    logic [5:0] st;
    assign st = {cmd_ready, busy, done, aborted, m_axis_tvalid, s_axis_tready};

    axis_channel_loader #(.NUM_CH(16), .BEAT_W(16), .IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mask       (cmd_mask),
        .cmd_beats      (cmd_beats),
        .abort          (abort),
        .channel_select (channel_select),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .cur_index      (cur_index),
        .beat_count     (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_mask = 16'h0001; cmd_beats = 16'd1;
        tick(); tick(); #1;
        total++;
        if (st !== 6'b100000) begin bad++; $display("FAIL reset_status got=%b exp=%b", st, 6'b100000); end
        total++;
        if ({channel_select, cur_index, beat_count} !== 36'h0) begin
            bad++; $display("FAIL reset_regs got sel=%h idx=%0d bc=%0d exp all zero", channel_select, cur_index, beat_count);
        end
        rst = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [5:0]  exp_st [7] = '{6'b100000, 6'b010000, 6'b010011, 6'b010011, 6'b010011, 6'b011000, 6'b100000};
        logic [15:0] exp_sel[7] = '{16'h0, 16'h4, 16'h4, 16'h4, 16'h4, 16'h0, 16'h0};
        for (int w = 0; w < 7; w++) begin
            tick();
            cmd_valid = (w == 0); cmd_mask = 16'h0004; cmd_beats = 16'd3;
            #1;
            total++;
            if (st !== exp_st[w] || channel_select !== exp_sel[w]) begin
                bad++; $display("FAIL single_w%0d got st=%b sel=%h exp st=%b sel=%h", w, st, channel_select, exp_st[w], exp_sel[w]);
            end
            if (w >= 1 && w <= 4) begin
                total++;
                if (cur_index !== 4'd2 || beat_count !== 16'(w >= 2 ? w - 2 : 0)) begin
                    bad++; $display("FAIL single_cnt_w%0d got idx=%0d bc=%0d exp idx=2 bc=%0d", w, cur_index, beat_count, (w >= 2 ? w - 2 : 0));
                end
            end
        end
    endtask

    task automatic test_multi();
        logic [5:0]  exp_st [12] = '{6'b100000, 6'b010000, 6'b010011, 6'b010011, 6'b010000, 6'b010011,
                                     6'b010011, 6'b010000, 6'b010011, 6'b010011, 6'b011000, 6'b100000};
        logic [15:0] exp_sel[12] = '{16'h0, 16'h0001, 16'h0001, 16'h0001, 16'h0010, 16'h0010,
                                     16'h0010, 16'h8000, 16'h8000, 16'h8000, 16'h0, 16'h0};
        logic [3:0]  exp_idx[12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd4, 4'd4, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
        int hs = 0;
        for (int w = 0; w < 12; w++) begin
            tick();
            cmd_valid = (w == 0); cmd_mask = 16'h8011; cmd_beats = 16'd2;
            #1;
            total++;
            if (st !== exp_st[w] || channel_select !== exp_sel[w]) begin
                bad++; $display("FAIL multi_w%0d got st=%b sel=%h exp st=%b sel=%h", w, st, channel_select, exp_st[w], exp_sel[w]);
            end
            if (w >= 1 && w <= 9) begin
                total++;
                if (cur_index !== exp_idx[w]) begin
                    bad++; $display("FAIL multi_idx_w%0d got=%0d exp=%0d", w, cur_index, exp_idx[w]);
                end
            end
            if (s_axis_tvalid && s_axis_tready) hs++;
        end
        total++;
        if (hs != 6) begin bad++; $display("FAIL multi_beats got=%0d exp=6", hs); end
    endtask

    task automatic test_backpressure();
        int  hs = 0;
        bit  seen_done = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_mask = 16'h0002; cmd_beats = 16'd4;
        for (int w = 1; w < 200 && !seen_done; w++) begin
            tick();
            cmd_valid     = 1'b0;
            m_axis_tready = (w % 2 == 1);
            s_axis_tvalid = 1'($urandom_range(0, 1));
            #1;
            if (done) begin
                seen_done = 1'b1;
                total++;
                if (hs != 4 || channel_select !== 16'h0) begin
                    bad++; $display("FAIL bp_done got beats=%0d sel=%h exp beats=4 sel=0", hs, channel_select);
                end
            end else begin
                total++;
                if (channel_select !== 16'h0002 || beat_count !== 16'(hs)) begin
                    bad++; $display("FAIL bp_w%0d got sel=%h bc=%0d exp sel=0002 bc=%0d", w, channel_select, beat_count, hs);
                end
                total++;
                if ((!m_axis_tready && s_axis_tready) || (m_axis_tvalid !== (s_axis_tvalid && w >= 2))) begin
                    bad++; $display("FAIL bp_gate_w%0d got tready=%b tvalid=%b", w, s_axis_tready, m_axis_tvalid);
                end
                if (s_axis_tvalid && s_axis_tready) hs++;
            end
        end
        total++;
        if (!seen_done) begin bad++; $display("FAIL bp_timeout got no done exp done within 200 cycles"); end
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        tick();
    endtask

    task automatic test_degenerate();
        logic [15:0] masks[2] = '{16'h0000, 16'h00FF};
        logic [15:0] beats[2] = '{16'd5, 16'd0};
        for (int c = 0; c < 2; c++) begin
            tick();
            cmd_valid = 1'b1; cmd_mask = masks[c]; cmd_beats = beats[c];
            tick();
            cmd_valid = 1'b0;
            #1;
            total++;
            if (st !== 6'b011000 || channel_select !== 16'h0) begin
                bad++; $display("FAIL degen%0d_done got st=%b sel=%h exp st=011000 sel=0000", c, st, channel_select);
            end
            tick(); #1;
            total++;
            if (st !== 6'b100000) begin bad++; $display("FAIL degen%0d_idle got st=%b exp=100000", c, st); end
        end
    endtask

    task automatic test_abort();
        logic [5:0]  exp_st [9] = '{6'b100000, 6'b010000, 6'b010011, 6'b010011, 6'b010011,
                                    6'b010011, 6'b010011, 6'b011100, 6'b100100};
        logic [15:0] exp_sel[9] = '{16'h0, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h1, 16'h0, 16'h0};
        for (int w = 0; w < 9; w++) begin
            tick();
            cmd_valid = (w == 0); cmd_mask = 16'h0003; cmd_beats = 16'd10;
            abort = (w == 6);
            #1;
            total++;
            if (st !== exp_st[w] || channel_select !== exp_sel[w]) begin
                bad++; $display("FAIL abort_w%0d got st=%b sel=%h exp st=%b sel=%h", w, st, channel_select, exp_st[w], exp_sel[w]);
            end
            if (w == 6) begin
                total++;
                if (beat_count !== 16'd4) begin bad++; $display("FAIL abort_bc got=%0d exp=4", beat_count); end
            end
        end
        abort = 1'b0;
        // Abort coinciding with the last beat still reports aborted.
        tick();
        cmd_valid = 1'b1; cmd_mask = 16'h0001; cmd_beats = 16'd1;
        tick();
        cmd_valid = 1'b0;
        #1;
        total++;
        if (st !== 6'b010000) begin bad++; $display("FAIL abort_clear got st=%b exp=010000", st); end
        tick();
        abort = 1'b1;
        #1;
        total++;
        if (st !== 6'b010011) begin bad++; $display("FAIL abort_last_stream got st=%b exp=010011", st); end
        tick();
        abort = 1'b0;
        #1;
        total++;
        if (st !== 6'b011100) begin bad++; $display("FAIL abort_last_done got st=%b exp=011100", st); end
        // Abort in IDLE does nothing.
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        total++;
        if (st !== 6'b100100) begin bad++; $display("FAIL abort_idle got st=%b exp=100100", st); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        for (int w = 0; w < 25; w++) begin
            tick();
            cmd_valid = (w == 0); cmd_mask = 16'hFFFF; cmd_beats = 16'd8;
            rst = (w == 22);
            #1;
            if (done) dones++;
            if (w == 22) begin
                total++;
                if (channel_select !== 16'h0004 || cur_index !== 4'd2 || beat_count !== 16'd2) begin
                    bad++; $display("FAIL rstmid_pre got sel=%h idx=%0d bc=%0d exp sel=0004 idx=2 bc=2", channel_select, cur_index, beat_count);
                end
            end
            if (w == 23) begin
                total++;
                if (st !== 6'b100000 || {channel_select, cur_index, beat_count} !== 36'h0) begin
                    bad++; $display("FAIL rstmid_post got st=%b sel=%h idx=%0d bc=%0d exp st=100000 zeros", st, channel_select, cur_index, beat_count);
                end
            end
        end
        total++;
        if (dones != 0 || st !== 6'b100000) begin
            bad++; $display("FAIL rstmid_nodone got dones=%0d st=%b exp dones=0 st=100000", dones, st);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_mask = '0; cmd_beats = '0; abort = 1'b0;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_degenerate();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
